// File: rtl/ibex_rf_write_arbiter.sv
// ibex_rf_write_arbiter
//
// Drives the single write port of the latch-based register file. It merges
// two write sources:
//   - the in-order writeback stage (primary, single cycle, no handshake);
//   - a long-latency compute unit (secondary, valid/ready). Its results are
//     buffered in a small FIFO and written through from the FIFO head.
// It also keeps a busy scoreboard of destinations reserved for the secondary
// unit, and bounds how long the FIFO head can be starved by the primary path.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   wb_we_i/wb_waddr_i/wb_wdata_i     primary write request
//   wb_stall_o                        core must hold its writeback this cycle
//   sec_valid_i/sec_ready_o           secondary result handshake
//   sec_waddr_i/sec_wdata_i           secondary result destination / data
//   rsv_valid_i/rsv_addr_i            destination reservation from ID
//   busy_o                            per-register pending-write bits
//   rf_we_o/rf_waddr_o/rf_wdata_o     register file write port
//   err_o                             one-cycle protocol-error pulse
module ibex_rf_write_arbiter #(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  output logic                 wb_stall_o,
  input  logic                 sec_valid_i,
  output logic                 sec_ready_o,
  input  logic [4:0]           sec_waddr_i,
  input  logic [DataWidth-1:0] sec_wdata_i,
  input  logic                 rsv_valid_i,
  input  logic [4:0]           rsv_addr_i,
  output logic [31:0]          busy_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(StarveLimit + 1);

  // Scoreboard index; on RV32E address bit 4 does not exist.
  function automatic logic [4:0] reg_idx(input logic [4:0] addr);
    reg_idx = RV32E ? {1'b0, addr[3:0]} : addr;
  endfunction

  logic [4:0]           fifo_addr [FifoDepth];
  logic [DataWidth-1:0] fifo_data [FifoDepth];
  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      count;
  logic [31:0]          busy_q, busy_d;
  logic [StW-1:0]       starve_cnt;
  logic                 stall_q, err_q, err_d;
  logic                 empty, full, push, head_wr, starve_hit;
  logic [4:0]           head_addr, head_idx, rsv_idx, sec_idx, wb_idx;
  logic [DataWidth-1:0] head_data;

  assign empty       = (count == '0);
  assign full        = (count == CntW'(FifoDepth));
  // Ready depends only on the registered fill level, never on a same-cycle pop.
  assign sec_ready_o = !full;
  assign push        = sec_valid_i && !full;
  assign head_addr   = fifo_addr[rd_ptr];
  assign head_data   = fifo_data[rd_ptr];

  assign head_idx = reg_idx(head_addr);
  assign rsv_idx  = reg_idx(rsv_addr_i);
  assign sec_idx  = reg_idx(sec_waddr_i);
  assign wb_idx   = reg_idx(wb_waddr_i);

  // During a stall cycle the head owns the port and the primary request is
  // ignored; the core holds it and retries next cycle.
  assign head_wr = !empty && (stall_q || !wb_we_i);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (head_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = head_addr;
      rf_wdata_o = head_data;
    end else if (wb_we_i && !stall_q) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end
  end

  // Clear for the written head first, then set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (head_wr) begin
      busy_d[head_idx] = 1'b0;
    end
    if (rsv_valid_i && (rsv_idx != 5'd0)) begin
      busy_d[rsv_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (RV32E) begin
      busy_d[31:16] = '0;
    end
  end

  // A reservation of a register whose pending write is retiring this very
  // cycle is a legitimate re-issue, not a double reservation.
  always_comb begin
    err_d = 1'b0;
    if (rsv_valid_i && busy_q[rsv_idx] && !(head_wr && (head_idx == rsv_idx))) begin
      err_d = 1'b1;
    end
    if (push && !busy_q[sec_idx]) begin
      err_d = 1'b1;
    end
    if (wb_we_i && busy_q[wb_idx]) begin
      err_d = 1'b1;
    end
  end

  // The stall flop fires on the cycle the head loses for the StarveLimit-th
  // time in a row; the head is then guaranteed the port on the next cycle.
  assign starve_hit = !empty && !head_wr && (starve_cnt == StW'(StarveLimit - 1));

  // Control state: pointers, fill level, scoreboard, starvation, error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy_q     <= '0;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (head_wr) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, head_wr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      busy_q     <= busy_d;
      starve_cnt <= (empty || head_wr) ? '0 : starve_cnt + 1'b1;
      stall_q    <= starve_hit;
      err_q      <= err_d;
    end
  end

  // FIFO storage: data only, never reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sec_waddr_i;
      fifo_data[wr_ptr] <= sec_wdata_i;
    end
  end

  assign busy_o     = busy_q;
  assign wb_stall_o = stall_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
module tb_ibex_rf_write_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_we, sec_valid, rsv_valid;
  logic [4:0]    wb_waddr, sec_waddr, rsv_addr;
  logic [DW-1:0] wb_wdata, sec_wdata;
  logic          wb_stall, sec_ready, rf_we, err;
  logic [31:0]   busy;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(
    .RV32E(1'b0), .DataWidth(DW), .FifoDepth(DEPTH), .StarveLimit(LIMIT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .wb_stall_o(wb_stall),
    .sec_valid_i(sec_valid), .sec_ready_o(sec_ready),
    .sec_waddr_i(sec_waddr), .sec_wdata_i(sec_wdata),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
    .busy_o(busy),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending secondary results as a queue, scoreboard as a
  // bit array, and the number of consecutive cycles the queue head lost.
  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_busy[32];
  int   m_lost;
  bit   m_stall;
  bit   m_err;

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_lost  = 0;
    m_stall = 1'b0;
    m_err   = 1'b0;
  endfunction

  task automatic idle_inputs();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    sec_valid = 0; sec_waddr = 0; sec_wdata = 0;
    rsv_valid = 0; rsv_addr = 0;
  endtask

  // One clock cycle: compare all outputs with the model, then advance the
  // model on the active edge using the inputs the DUT sampled.
  task automatic tick();
    logic [72:0]   exp_v, act_v;
    logic          e_we;
    logic [4:0]    e_addr;
    logic [DW-1:0] e_data;
    logic [31:0]   bv;
    bit            hw, pushed, was_nonempty;
    #1;
    hw     = (q.size() > 0) && (m_stall || !wb_we);
    e_we   = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (hw) begin
      e_we = 1'b1; e_addr = q[0].a; e_data = q[0].d;
    end else if (wb_we && !m_stall) begin
      e_we = 1'b1; e_addr = wb_waddr; e_data = wb_wdata;
    end
    for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
    exp_v = {e_we, e_addr, e_data, (q.size() < DEPTH), m_stall, bv, m_err};
    act_v = {rf_we, rf_waddr, rf_wdata, sec_ready, wb_stall, busy, err};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t {we,waddr,wdata,ready,stall,busy,err} got %h expected %h",
               $time, act_v, exp_v);
    end
    @(posedge clk);
    pushed       = sec_valid && (q.size() < DEPTH);
    was_nonempty = (q.size() > 0);
    m_err = (rsv_valid && m_busy[rsv_addr] && !(hw && (q[0].a == rsv_addr))) ||
            (pushed && !m_busy[sec_waddr]) ||
            (wb_we && m_busy[wb_waddr]);
    if (hw) begin
      m_busy[q[0].a] = 1'b0;
      void'(q.pop_front());
    end
    if (rsv_valid && (rsv_addr != 0)) m_busy[rsv_addr] = 1'b1;
    if (pushed) q.push_back('{a: sec_waddr, d: sec_wdata});
    if (!was_nonempty || hw) m_lost = 0;
    else m_lost = m_lost + 1;
    m_stall = (m_lost == LIMIT);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rf_we, sec_ready, busy, err, wb_stall} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got we=%b ready=%b busy=%h err=%b stall=%b required we=0 ready=1 busy=0 err=0 stall=0",
               rf_we, sec_ready, busy, err, wb_stall);
    end
    checks++;
    if ({rf_waddr, rf_wdata} !== 37'h0) begin
      errors++;
      $display("FAIL reset_port_zero got waddr=%h wdata=%h required 0", rf_waddr, rf_wdata);
    end
    do_reset();
    repeat (3) tick();
  endtask

  task automatic test_single_write();
    do_reset();
    rsv_valid = 1; rsv_addr = 5;
    tick();
    rsv_valid = 0;
    #1;
    checks++;
    if (busy[5] !== 1'b1) begin
      errors++; $display("FAIL busy_set x5 got %b required 1", busy[5]);
    end
    sec_valid = 1; sec_waddr = 5; sec_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL no_bypass got rf_we=%b required 0", rf_we);
    end
    tick();
    sec_valid = 0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sec_write got we=%b addr=%0d data=%h required we=1 addr=5 data=deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    #1;
    checks++;
    if (busy[5] !== 1'b0) begin
      errors++; $display("FAIL busy_clear x5 got %b required 0", busy[5]);
    end
    tick();
  endtask

  task automatic test_fifo_fill();
    int n;
    do_reset();
    rsv_valid = 1; rsv_addr = 3; tick();
    rsv_addr = 4; tick();
    rsv_valid = 0;
    wb_we = 1; wb_waddr = 10; wb_wdata = $urandom;
    sec_valid = 1; sec_waddr = 3; sec_wdata = 32'hA0A0_0003; tick();
    sec_waddr = 4; sec_wdata = 32'hB0B0_0004; tick();
    #1;
    checks++;
    if (sec_ready !== 1'b0) begin
      errors++; $display("FAIL fifo_full_ready got %b required 0", sec_ready);
    end
    sec_waddr = 3; sec_wdata = 32'hC0C0_0003;
    n = 0;
    while (sec_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != LIMIT) begin
      errors++; $display("FAIL third_held cycles got %0d required %0d", n, LIMIT);
    end
    tick();
    sec_valid = 0; wb_we = 0;
    repeat (6) tick();
  endtask

  task automatic test_starvation();
    do_reset();
    rsv_valid = 1; rsv_addr = 6; tick();
    rsv_valid = 0;
    wb_we = 1; wb_waddr = 11; wb_wdata = 32'h1111_2222;
    sec_valid = 1; sec_waddr = 6; sec_wdata = 32'h6666_0006;
    tick();
    sec_valid = 0;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      checks++;
      if ({wb_stall, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd11}) begin
        errors++;
        $display("FAIL starve_lost%0d got stall=%b we=%b addr=%0d required stall=0 we=1 addr=11",
                 i, wb_stall, rf_we, rf_waddr);
      end
      tick();
    end
    #1;
    checks++;
    if ({wb_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd6, 32'h6666_0006}) begin
      errors++;
      $display("FAIL starve_stall got stall=%b we=%b addr=%0d data=%h required stall=1 we=1 addr=6 data=66660006",
               wb_stall, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    #1;
    checks++;
    if ({wb_stall, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd11, 32'h1111_2222}) begin
      errors++;
      $display("FAIL starve_retry got stall=%b we=%b addr=%0d data=%h required stall=0 we=1 addr=11 data=11112222",
               wb_stall, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    wb_we = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    rsv_valid = 1; rsv_addr = 7; tick();
    rsv_valid = 0;
    sec_valid = 1; sec_waddr = 7; sec_wdata = 32'h7777_0007; tick();
    sec_valid = 0;
    rsv_valid = 1; rsv_addr = 7;
    #1;
    checks++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd7}) begin
      errors++; $display("FAIL simul_write got we=%b addr=%0d required we=1 addr=7", rf_we, rf_waddr);
    end
    tick();
    rsv_valid = 0;
    #1;
    checks++;
    if ({busy[7], err} !== 2'b10) begin
      errors++; $display("FAIL simul_busy got busy7=%b err=%b required busy7=1 err=0", busy[7], err);
    end
    tick();
  endtask

  task automatic test_errors();
    do_reset();
    rsv_valid = 1; rsv_addr = 9; tick();
    rsv_valid = 0;
    wb_we = 1; wb_waddr = 9; wb_wdata = 32'h9; tick();
    wb_we = 0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_waw got %b required 1", err);
    end
    tick();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_one_cycle got %b required 0", err);
    end
    rsv_valid = 1; rsv_addr = 9; tick();
    rsv_valid = 0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_double_rsv got %b required 1", err);
    end
    tick();
    // Fill the FIFO behind a continuous primary stream, then reset.
    rsv_valid = 1; rsv_addr = 1; tick();
    rsv_addr = 2; tick();
    rsv_valid = 0;
    wb_we = 1; wb_waddr = 12; wb_wdata = 32'hC;
    sec_valid = 1; sec_waddr = 1; sec_wdata = 32'h1; tick();
    sec_waddr = 2; sec_wdata = 32'h2; tick();
    sec_valid = 0;
    #1;
    checks++;
    if ({sec_ready, busy[1], busy[2]} !== 3'b011) begin
      errors++; $display("FAIL pre_reset_full got ready=%b busy1=%b busy2=%b required 0 1 1",
                         sec_ready, busy[1], busy[2]);
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sec_ready, busy, rf_we} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL async_reset got ready=%b busy=%h we=%b required ready=1 busy=0 we=0",
                         sec_ready, busy, rf_we);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wb_we     = ($urandom_range(0, 99) < 45);
      wb_waddr  = 5'($urandom_range(0, 31));
      wb_wdata  = $urandom;
      sec_valid = ($urandom_range(0, 99) < 40);
      sec_waddr = 5'($urandom_range(0, 31));
      sec_wdata = $urandom;
      rsv_valid = ($urandom_range(0, 99) < 30);
      rsv_addr  = 5'($urandom_range(0, 31));
      tick();
    end
    idle_inputs();
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_fifo_fill();
    test_starvation();
    test_simultaneous();
    test_errors();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
